// File: rtl/nbit_seq_alu.sv
// Sequential N-bit ALU: single-cycle logic/arithmetic ops, WIDTH-cycle shift-add multiply.
// One result register set feeds all outputs; done pulses for exactly one cycle per completion.
module nbit_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             cf,
  output logic             zf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_XOR = 4'd2,  OP_NOT = 4'd3,
    OP_INC = 4'd4,  OP_DEC = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7,
    OP_TST = 4'd8,  OP_ADD = 4'd9,  OP_ADC = 4'd10, OP_SUB = 4'd11,
    OP_MUL = 4'd12
  } op_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } state_e;

  state_e             r_state;
  logic               r_ready;
  logic               r_done;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic               r_cf;
  logic               r_zf;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;

  logic [WIDTH-1:0]   w_res;
  logic               w_cf;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;

  // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_res = '0;
    w_cf  = 1'b0;
    w_sum = '0;
    case (op)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_INC: begin
        w_sum = {1'b0, a} + (WIDTH+1)'(1);
        {w_cf, w_res} = w_sum;
      end
      OP_DEC: begin
        w_res = a - WIDTH'(1);
        w_cf  = (a == '0);
      end
      OP_SHL: {w_cf, w_res} = {a, 1'b0};
      OP_SHR: {w_res, w_cf} = {1'b0, a};
      OP_TST: w_res = a;
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        {w_cf, w_res} = w_sum;
      end
      OP_ADC: begin
        w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        {w_cf, w_res} = w_sum;
      end
      OP_SUB: begin
        w_res = a - b;
        w_cf  = (a < b);
      end
      default: ;
    endcase
  end

  // Partial product including the current multiplier bit; on the last iteration this is the full product.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              r_state  <= S_MUL_RUN;
              r_ready  <= 1'b0;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, a};
              r_mplier <= b;
            end else begin
              r_res    <= w_res;
              r_res_hi <= '0;
              r_cf     <= w_cf;
              r_zf     <= (w_res == '0);
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_done   <= 1'b1;
            r_res    <= w_acc_next[WIDTH-1:0];
            r_res_hi <= w_acc_next[2*WIDTH-1:WIDTH];
            r_cf     <= (w_acc_next[2*WIDTH-1:WIDTH] != '0);
            r_zf     <= (w_acc_next == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign r     = r_res;
  assign r_hi  = r_res_hi;
  assign cf    = r_cf;
  assign zf    = r_zf;

endmodule

// File: tb/tb_nbit_seq_alu.sv
// Scoreboard bench for nbit_seq_alu: stimulus pushes model results, a negedge monitor pops on done.
// Directed cases cover carries, borrows, multiply latency/ignore/abort and undefined opcodes.
module tb_nbit_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         done;
  logic [W-1:0] r;
  logic [W-1:0] r_hi;
  logic         cf;
  logic         zf;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic         cf;
    logic         zf;
  } res_t;

  res_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  nbit_seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .done  (done),
    .r     (r),
    .r_hi  (r_hi),
    .cf    (cf),
    .zf    (zf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour written straight from the opcode table with plain arithmetic.
  function automatic res_t model(input logic [3:0] f_op, input logic [W-1:0] fa,
                                 input logic [W-1:0] fb, input logic fc);
    res_t x;
    logic [2*W-1:0] p;
    x = '0;
    case (f_op)
      4'd0:  x.r = fa & fb;
      4'd1:  x.r = fa | fb;
      4'd2:  x.r = fa ^ fb;
      4'd3:  x.r = ~fa;
      4'd4:  {x.cf, x.r} = fa + 1;
      4'd5:  begin x.r = fa - 1; x.cf = (fa == 0); end
      4'd6:  {x.cf, x.r} = {fa, 1'b0};
      4'd7:  {x.r, x.cf} = {1'b0, fa};
      4'd8:  x.r = fa;
      4'd9:  {x.cf, x.r} = fa + fb;
      4'd10: {x.cf, x.r} = fa + fb + fc;
      4'd11: begin x.r = fa - fb; x.cf = (fa < fb); end
      4'd12: begin
        p = fa * fb;
        {x.rh, x.r} = p;
        x.cf = (x.rh != 0);
      end
      default: ;
    endcase
    x.zf = (x.r == 0) && (x.rh == 0);
    return x;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with r=0x%0h, expected no pending result (t=%0t)", r, $time);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard_result", {r, r_hi, cf, zf}, e);
        end
      end
    end
  end

  // Called just after a rising edge; waits (bounded) for ready, then presents one request for one edge.
  task automatic issue(input logic [3:0] f_op, input logic [W-1:0] fa, input logic [W-1:0] fb,
                       input logic fc, input bit expect_done);
    int t = 0;
    while (ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_before_issue", ready, 1);
    op    = f_op;
    a     = fa;
    b     = fb;
    cin   = fc;
    start = 1'b1;
    if (expect_done) exp_q.push_back(model(f_op, fa, fb, fc));
    @(posedge clk); #1;
    start = 1'b0;
    if (f_op != 4'd12) check("done_next_cycle", done, 1);
  endtask

  task automatic check_res(input string name, input logic [W-1:0] er, input logic [W-1:0] erh,
                           input logic ecf, input logic ezf);
    check(name, {r, r_hi, cf, zf}, {er, erh, ecf, ezf});
  endtask

  initial begin
    logic [2*W+1:0] held;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check_res("reset_outputs", 8'h00, 8'h00, 1'b0, 1'b1);

    issue(4'd9, 8'hFF, 8'h01, 1'b0, 1);
    check_res("add_ff_01", 8'h00, 8'h00, 1'b1, 1'b1);
    issue(4'd10, 8'h7F, 8'h00, 1'b1, 1);
    check_res("adc_7f_00_c1", 8'h80, 8'h00, 1'b0, 1'b0);
    issue(4'd5, 8'h00, 8'h00, 1'b0, 1);
    check_res("dec_00", 8'hFF, 8'h00, 1'b1, 1'b0);
    issue(4'd11, 8'h03, 8'h05, 1'b0, 1);
    check_res("sub_03_05", 8'hFE, 8'h00, 1'b1, 1'b0);
    issue(4'd7, 8'h01, 8'h00, 1'b0, 1);
    check_res("shr_01", 8'h00, 8'h00, 1'b1, 1'b1);
    issue(4'd6, 8'h81, 8'h00, 1'b0, 1);
    check_res("shl_81", 8'h02, 8'h00, 1'b1, 1'b0);

    // Multiply latency, ready low and held outputs for the whole run.
    held = {r, r_hi, cf, zf};
    issue(4'd12, 8'hFF, 8'hFF, 1'b0, 1);
    for (int i = 0; i < W; i++) begin
      check("mul_ready_low", ready, 0);
      check("mul_no_early_done", done, 0);
      check("mul_outputs_held", {r, r_hi, cf, zf}, held);
      @(posedge clk); #1;
    end
    check("mul_done_at_width", done, 1);
    check("mul_ready_back", ready, 1);
    check_res("mul_ff_ff", 8'h01, 8'hFE, 1'b1, 1'b0);

    // Start pulsed mid-multiply with changed operands must be ignored.
    issue(4'd12, 8'h0F, 8'h11, 1'b0, 1);
    repeat (2) begin @(posedge clk); #1; end
    op = 4'd9; a = 8'h03; b = 8'h04; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'hAA; b = 8'h55; op = 4'd2;
    issue(4'd9, 8'h03, 8'h04, 1'b0, 1);
    check_res("add_after_mul", 8'h07, 8'h00, 1'b0, 1'b0);

    // Reset three cycles into a multiply aborts it with no done pulse.
    issue(4'd12, 8'hC3, 8'h5A, 1'b0, 0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", ready, 1);
    check("abort_done", done, 0);
    check_res("abort_outputs", 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (W + 2) begin @(posedge clk); #1; end

    // Start coinciding with reset is discarded.
    reset = 1'b1; start = 1'b1; op = 4'd9; a = 8'h01; b = 8'h01;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("reset_start_no_done", done, 0);
    check_res("reset_start_outputs", 8'h00, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("reset_start_still_no_done", done, 0);

    issue(4'd14, 8'h55, 8'h33, 1'b1, 1);
    check_res("undef_op14", 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) issue(4'd2, W'($urandom), W'($urandom), 1'b0, 1);

    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (W + 3) begin @(posedge clk); #1; end
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nbit_seq_alu.md
NBIT_SEQ_ALU -- requirements
Module: nbit_seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request; accepted only on an edge where ready=1.
REQ-005 op  input  4  opcode, sampled on accept.
REQ-006 a, b  input  WIDTH each  operands, sampled on accept.
REQ-007 cin  input  1  carry/borrow-in for ADC, sampled on accept.
REQ-008 ready  output  1  high when idle and able to accept.
REQ-009 done  output  1  one-cycle pulse; result outputs updated in the same cycle.
REQ-010 r  output  WIDTH  result, low half for MUL.
REQ-011 r_hi  output  WIDTH  high half of MUL product; 0 for all other ops.
REQ-012 cf, zf  output  1 each  carry/borrow flag and zero flag.

Function
REQ-013 Opcodes SHALL be: 0 AND, 1 OR, 2 XOR, 3 NOT(~a), 4 INC, 5 DEC, 6 SHL, 7 SHR, 8 TST(r=a), 9 ADD, 10 ADC, 11 SUB, 12 MUL; 13-15 undefined.
REQ-014 AND/OR/XOR/NOT/TST SHALL give cf=0.
REQ-015 INC: r=a+1 mod 2^WIDTH, cf=carry out; DEC: r=a-1 mod 2^WIDTH, cf=(a==0).
REQ-016 SHL: {cf,r}={a,0}; SHR: {r,cf}={0,a}; logical, one bit.
REQ-017 ADD: {cf,r}=a+b; ADC: {cf,r}=a+b+cin; SUB: r=a-b mod 2^WIDTH, cf=(a<b) unsigned borrow.
REQ-018 MUL: {r_hi,r}=a*b unsigned, 2*WIDTH bits; cf=(r_hi!=0).
REQ-019 zf SHALL be 1 iff r==0 and r_hi==0.
REQ-020 Undefined opcodes SHALL complete as single-cycle ops with r=0, r_hi=0, cf=0, zf=1.
REQ-021 FSM states: IDLE (ready=1), MUL_RUN (ready=0); non-MUL ops never leave IDLE.
REQ-022 Non-MUL op accepted at edge k: r/r_hi/cf/zf registered and done=1 during cycle following edge k; ready stays 1, so back-to-back starts complete one per cycle.
REQ-023 MUL accepted at edge k: enter MUL_RUN, shift-add one multiplier bit per cycle for WIDTH cycles; done=1 and results valid after edge k+WIDTH, return to IDLE on that edge; latency WIDTH cycles.
REQ-024 During MUL_RUN start SHALL be ignored and operands/op changes SHALL not affect the running product.
REQ-025 r, r_hi, cf, zf SHALL hold their last values between done pulses, including through MUL_RUN.
REQ-026 done SHALL be 0 in every cycle not immediately following a completion edge.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, ready=1, done=0, r=0, r_hi=0, cf=0, zf=1, iteration counter and partial product cleared.
REQ-028 reset SHALL take priority over start and over an in-progress MUL; an aborted MUL SHALL produce no done pulse.
REQ-029 start asserted with reset on the same edge SHALL be discarded.

Verification (WIDTH=8)
REQ-030 ADD a=0xFF b=0x01 -> next cycle done=1, r=0x00, cf=1, zf=1; ADC a=0x7F b=0x00 cin=1 -> r=0x80, cf=0, zf=0.
REQ-031 DEC a=0x00 -> r=0xFF, cf=1; SUB a=0x03 b=0x05 -> r=0xFE, cf=1; SHR a=0x01 -> r=0x00, cf=1, zf=1.
REQ-032 MUL a=0xFF b=0xFF -> done exactly 8 cycles after accept, r_hi=0xFE, r=0x01, cf=1, zf=0; ready=0 for those 8 cycles.
REQ-033 MUL a=0x0F b=0x11 then start ADD pulsed mid-run -> ADD ignored, result r_hi=0x00, r=0xFF, cf=0; ADD accepted only after ready returns.
REQ-034 Reset asserted 3 cycles into MUL -> following cycle ready=1, done=0, r=0, zf=1; no done pulse for aborted op.
REQ-035 Opcode 14 with a=0x55 -> done next cycle, r=0, r_hi=0, cf=0, zf=1; four back-to-back XORs -> four consecutive done pulses.
